// File: rtl/clock_pkg.sv
// Shared definitions for the clock/timer display path.
// Contents: edit field codes, display-state codes, the dash digit code and
// BCD increment/decrement helpers that wrap at a caller-supplied limit.
package clock_pkg;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_SEC  = 2'd1,
        FLD_MIN  = 2'd2,
        FLD_HOUR = 2'd3
    } field_t;

    localparam logic [2:0] TIME_DISP       = 3'd0;
    localparam logic [2:0] TIME_EDIT_HOUR  = 3'd1;
    localparam logic [2:0] TIME_EDIT_MIN   = 3'd2;
    localparam logic [2:0] TIMER_DISP      = 3'd3;
    localparam logic [2:0] TIMER_EDIT_SEC  = 3'd4;
    localparam logic [2:0] TIMER_EDIT_MIN  = 3'd5;
    localparam logic [2:0] TIMER_EDIT_HOUR = 3'd6;

    localparam logic [3:0] DASH_CODE = 4'hA;
    localparam logic [7:0] LIM_MS    = 8'h59;
    localparam logic [7:0] LIM_HOUR  = 8'h99;

    // Two-digit BCD +1, wrapping from lim back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v == lim) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD -1, wrapping from 00 up to lim.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = lim;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Auto-repeat step generator for one debounced active-low button.
// Ports: clk, rst (sync, active-high), btn_n (pressed = 0),
//        step (one-cycle pulse: on press, after REP_DELAY held cycles,
//        then every REP_PERIOD cycles while held).
// step is combinational so the consumer updates on the edge that first
// samples the button low.
module btn_repeat #(
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic step
);

    localparam int HOLD_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    logic          prev_r;
    logic [HW-1:0] hold_r;   // cycles since the last step while held
    logic          rep_r;    // set once the initial delay has elapsed
    logic          fall_s;
    logic          delay_hit_s;
    logic          period_hit_s;

    // Step sources: press edge, end of initial delay, each repeat period.
    always_comb begin
        fall_s       = prev_r & ~btn_n;
        delay_hit_s  = ~btn_n & ~prev_r & ~rep_r & (hold_r == HW'(REP_DELAY));
        period_hit_s = ~btn_n & ~prev_r &  rep_r & (hold_r == HW'(REP_PERIOD));
        step         = fall_s | delay_hit_s | period_hit_s;
    end

    // Hold counter restarts at every step so each interval is measured afresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b1;
            hold_r <= '0;
            rep_r  <= 1'b0;
        end else begin
            prev_r <= btn_n;
            if (btn_n) begin
                hold_r <= '0;
                rep_r  <= 1'b0;
            end else if (step) begin
                hold_r <= HW'(1);
                rep_r  <= ~fall_s;
            end else begin
                hold_r <= hold_r + HW'(1);
                rep_r  <= rep_r;
            end
        end
    end

endmodule

// File: rtl/countdown_bank.sv
// Bank of N_CH independent hh:mm:ss countdown timers.
// Ports: clk, rst (sync, active-high), ch_sel (channel shown/edited),
//        field (0 none, 1 sec, 2 min, 3 hour), start/stop (one-cycle pulses
//        for the selected channel), up_btn/down_btn (active-low),
//        led7..led0 ({blink, dot, bcd} digits of the selected channel),
//        ring/running (per-channel alarm and run flags).
module countdown_bank
    import clock_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int TICK_CYC   = 50_000_000,
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 5_000_000,
    parameter int RING_SEC   = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
    input  logic [1:0]                             field,
    input  logic                                   start,
    input  logic                                   stop,
    input  logic                                   up_btn,
    input  logic                                   down_btn,
    output logic [5:0]                             led0,
    output logic [5:0]                             led1,
    output logic [5:0]                             led2,
    output logic [5:0]                             led3,
    output logic [5:0]                             led4,
    output logic [5:0]                             led5,
    output logic [5:0]                             led6,
    output logic [5:0]                             led7,
    output logic [N_CH-1:0]                        ring,
    output logic [N_CH-1:0]                        running
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int RW = $clog2(RING_SEC + 1);

    logic [PW-1:0] presc_r;
    logic          tick_s;
    logic          both_low_s;
    logic          up_step_s;
    logic          down_step_s;
    logic          edit_en_s;
    logic          inc_s;
    logic          dec_s;
    logic [N_CH-1:0] run_s;
    logic [N_CH-1:0] ring_s;
    logic [7:0]    hour_s [N_CH];
    logic [7:0]    min_s  [N_CH];
    logic [7:0]    sec_s  [N_CH];
    logic [3:0]    sel4_s;

    assign tick_s = (presc_r == PW'(TICK_CYC - 1));

    // Shared 1 s prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Both buttons low is treated as neither pressed, which also clears
    // both hold counters.
    assign both_low_s = ~up_btn & ~down_btn;

    btn_repeat #(.REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)) u_up (
        .clk   (clk),
        .rst   (rst),
        .btn_n (up_btn | both_low_s),
        .step  (up_step_s)
    );

    btn_repeat #(.REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)) u_down (
        .clk   (clk),
        .rst   (rst),
        .btn_n (down_btn | both_low_s),
        .step  (down_step_s)
    );

    assign edit_en_s = (field != 2'd0) & ~run_s[ch_sel];
    assign inc_s     = edit_en_s & up_step_s;
    assign dec_s     = edit_en_s & down_step_s;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [7:0]    hour_r, min_r, sec_r;
        logic [7:0]    hour_n_s, min_n_s, sec_n_s;
        logic          run_r;
        logic [RW-1:0] ring_cnt_r;
        logic          sel_s, zero_s, last_s;
        logic          stop_s, start_s, go_s, dec_en_s;

        assign sel_s    = (ch_sel == CW'(i));
        assign zero_s   = ({hour_r, min_r, sec_r} == 24'h000000);
        assign last_s   = ({hour_r, min_r, sec_r} == 24'h000001);
        assign stop_s   = sel_s & stop;
        assign start_s  = sel_s & start & ~stop;
        assign go_s     = start_s & ~run_r & ~zero_s;
        // stop beats a coincident tick
        assign dec_en_s = run_r & tick_s & ~stop_s;

        // Next time value: countdown with borrow, or a single-field edit.
        always_comb begin
            hour_n_s = hour_r;
            min_n_s  = min_r;
            sec_n_s  = sec_r;
            if (dec_en_s) begin
                sec_n_s = bcd_dec(sec_r, LIM_MS);
                if (sec_r == 8'h00) begin
                    min_n_s = bcd_dec(min_r, LIM_MS);
                    if (min_r == 8'h00) begin
                        hour_n_s = bcd_dec(hour_r, LIM_HOUR);
                    end else begin
                        hour_n_s = hour_r;
                    end
                end else begin
                    min_n_s = min_r;
                end
            end else if (sel_s & (inc_s | dec_s)) begin
                case (field_t'(field))
                    FLD_SEC:  sec_n_s  = inc_s ? bcd_inc(sec_r, LIM_MS)    : bcd_dec(sec_r, LIM_MS);
                    FLD_MIN:  min_n_s  = inc_s ? bcd_inc(min_r, LIM_MS)    : bcd_dec(min_r, LIM_MS);
                    FLD_HOUR: hour_n_s = inc_s ? bcd_inc(hour_r, LIM_HOUR) : bcd_dec(hour_r, LIM_HOUR);
                    default:  sec_n_s  = sec_r;
                endcase
            end else begin
                sec_n_s = sec_r;
            end
        end

        // Channel time, run flag and ring counter.
        always_ff @(posedge clk) begin
            if (rst) begin
                hour_r     <= 8'h00;
                min_r      <= 8'h00;
                sec_r      <= 8'h00;
                run_r      <= 1'b0;
                ring_cnt_r <= '0;
            end else begin
                hour_r <= hour_n_s;
                min_r  <= min_n_s;
                sec_r  <= sec_n_s;
                if (stop_s) begin
                    run_r <= 1'b0;
                end else if (go_s) begin
                    run_r <= 1'b1;
                end else if (dec_en_s & last_s) begin
                    run_r <= 1'b0;
                end else begin
                    run_r <= run_r;
                end
                if (stop_s | start_s) begin
                    ring_cnt_r <= '0;
                end else if (dec_en_s & last_s) begin
                    ring_cnt_r <= RW'(RING_SEC);
                end else if (tick_s && (ring_cnt_r != '0)) begin
                    ring_cnt_r <= ring_cnt_r - RW'(1);
                end else begin
                    ring_cnt_r <= ring_cnt_r;
                end
            end
        end

        assign run_s[i]  = run_r;
        assign ring_s[i] = (ring_cnt_r != '0);
        assign hour_s[i] = hour_r;
        assign min_s[i]  = min_r;
        assign sec_s[i]  = sec_r;
    end

    assign running = run_s;
    assign ring    = ring_s;
    assign sel4_s  = 4'(ch_sel);

    // Registered digit outputs for the selected channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            led0 <= 6'b0;
            led1 <= 6'b0;
            led2 <= 6'b0;
            led3 <= 6'b0;
            led4 <= 6'b0;
            led5 <= 6'b0;
            led6 <= 6'b0;
            led7 <= 6'b0;
        end else begin
            led7 <= {2'b00, sel4_s};
            led6 <= {2'b00, DASH_CODE};
            led5 <= {edit_en_s & (field == 2'd3), 1'b0, hour_s[ch_sel][7:4]};
            led4 <= {edit_en_s & (field == 2'd3), 1'b1, hour_s[ch_sel][3:0]};
            led3 <= {edit_en_s & (field == 2'd2), 1'b0, min_s[ch_sel][7:4]};
            led2 <= {edit_en_s & (field == 2'd2), 1'b1, min_s[ch_sel][3:0]};
            led1 <= {edit_en_s & (field == 2'd1), 1'b0, sec_s[ch_sel][7:4]};
            led0 <= {edit_en_s & (field == 2'd1), 1'b0, sec_s[ch_sel][3:0]};
        end
    end

endmodule

// File: tb/tb_countdown_bank.sv
module tb_countdown_bank;

    localparam int N_CH       = 4;
    localparam int TICK_CYC   = 10;
    localparam int REP_DELAY  = 20;
    localparam int REP_PERIOD = 5;
    localparam int RING_SEC   = 3;

    logic       clk = 1'b0;
    logic       rst, start, stop, up_btn, down_btn;
    logic [1:0] ch_sel, field;
    logic [5:0] led0, led1, led2, led3, led4, led5, led6, led7;
    logic [3:0] ring, running;

    int checks = 0;
    int errors = 0;
    int bcyc   = 0;

    countdown_bank #(
        .N_CH(N_CH), .TICK_CYC(TICK_CYC), .REP_DELAY(REP_DELAY),
        .REP_PERIOD(REP_PERIOD), .RING_SEC(RING_SEC)
    ) dut (
        .clk(clk), .rst(rst), .ch_sel(ch_sel), .field(field),
        .start(start), .stop(stop), .up_btn(up_btn), .down_btn(down_btn),
        .led0(led0), .led1(led1), .led2(led2), .led3(led3),
        .led4(led4), .led5(led5), .led6(led6), .led7(led7),
        .ring(ring), .running(running)
    );

    always #5 clk = ~clk;

    // Cycle count since reset; the prescaler position is bcyc mod TICK_CYC.
    always @(posedge clk) begin
        if (rst) bcyc <= 0;
        else     bcyc <= bcyc + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic press_up();
        up_btn = 1'b0; step(1); up_btn = 1'b1; step(1);
    endtask

    task automatic press_down();
        down_btn = 1'b0; step(1); down_btn = 1'b1; step(1);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(1); stop = 1'b0;
    endtask

    // Advance until just after the edge that ends the next tick cycle.
    task automatic wait_tick();
        int guard = 0;
        while ((bcyc % TICK_CYC) != (TICK_CYC - 1) && guard < 100) begin
            step(1);
            guard++;
        end
        chk("tick_bound", 64'(guard < 100), 64'd1);
        step(1);
    endtask

    function automatic logic [63:0] all_leds();
        return 64'({led7, led6, led5, led4, led3, led2, led1, led0});
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; up_btn = 1'b1; down_btn = 1'b1;
        ch_sel = 2'd0; field = 2'd0;
        step(3);
        chk("reset_leds", all_leds(), 64'h0);
        chk("reset_running", 64'(running), 64'h0);
        chk("reset_ring", 64'(ring), 64'h0);
        rst = 1'b0;
        step(1);
        chk("first_display", all_leds(),
            64'({6'h00, 6'h0A, 6'h00, 6'h10, 6'h00, 6'h10, 6'h00, 6'h00}));

        // Load ch1 with 00:01:02
        ch_sel = 2'd1; field = 2'd1;
        press_up(); press_up();
        field = 2'd2;
        press_up();
        chk("ch1_loaded", all_leds(),
            64'({6'h01, 6'h0A, 6'h00, 6'h10, 6'h20, 6'h31, 6'h00, 6'h02}));
        field = 2'd0;
        pulse_start();
        chk("ch1_start", 64'(running), 64'h2);
        for (int t = 0; t < 61; t++) wait_tick();
        chk("ch1_tick61_run", 64'(running), 64'h2);
        chk("ch1_tick61_ring", 64'(ring), 64'h0);
        wait_tick();
        chk("ch1_done_run", 64'(running), 64'h0);
        chk("ch1_done_ring", 64'(ring), 64'h2);
        wait_tick(); wait_tick();
        chk("ring_2ticks", 64'(ring), 64'h2);
        wait_tick();
        chk("ring_3ticks", 64'(ring), 64'h0);
        step(1);
        chk("ch1_zero_disp", 64'({led3, led2, led1, led0}), 64'({6'h00, 6'h10, 6'h00, 6'h00}));

        // Edit wrap
        field = 2'd1;
        press_down();
        chk("sec_wrap_down", 64'({led1, led0}), 64'({6'h25, 6'h29}));
        press_up();
        chk("sec_wrap_up", 64'({led3, led2, led1, led0}), 64'({6'h00, 6'h10, 6'h20, 6'h20}));
        field = 2'd3;
        press_down();
        chk("hour_wrap_down", 64'({led5, led4}), 64'({6'h29, 6'h39}));
        press_up();
        chk("hour_wrap_up", 64'({led5, led4}), 64'({6'h20, 6'h30}));

        // Auto-repeat on ch2
        ch_sel = 2'd2; field = 2'd1;
        up_btn = 1'b0; step(40); up_btn = 1'b1; step(2);
        chk("autorepeat", 64'({led7, led1, led0}), 64'({6'h02, 6'h20, 6'h25}));
        up_btn = 1'b0; down_btn = 1'b0; step(30); up_btn = 1'b1; down_btn = 1'b1; step(2);
        chk("both_low", 64'({led1, led0}), 64'({6'h20, 6'h25}));

        // Editing blocked while running
        field = 2'd0;
        wait_tick();
        pulse_start();
        chk("ch2_start", 64'(running), 64'h4);
        wait_tick();
        field = 2'd1;
        press_up();
        chk("edit_blocked", 64'({led1, led0}), 64'({6'h00, 6'h04}));
        pulse_stop();
        chk("ch2_stop", 64'(running), 64'h0);
        step(1);
        chk("blink_after_stop", 64'({led1, led0}), 64'({6'h20, 6'h24}));

        // stop coincident with a tick
        wait_tick();
        pulse_start();
        chk("ch2_restart", 64'(running), 64'h4);
        begin
            int guard = 0;
            while ((bcyc % TICK_CYC) != (TICK_CYC - 1) && guard < 100) begin
                step(1);
                guard++;
            end
            chk("align_bound", 64'(guard < 100), 64'd1);
        end
        pulse_stop();
        chk("stop_tick_run", 64'(running), 64'h0);
        step(1);
        chk("stop_tick_nodec", 64'({led1, led0}), 64'({6'h20, 6'h24}));

        // start on 00:00:00 is ignored
        ch_sel = 2'd3; field = 2'd0;
        pulse_start();
        chk("start_zero", 64'(running), 64'h0);
        step(1);
        chk("ch3_sel", 64'(led7), 64'h03);

        // rst during ring
        field = 2'd1;
        press_up();
        field = 2'd0;
        pulse_start();
        chk("ch3_start", 64'(running), 64'h8);
        wait_tick();
        chk("ch3_ring", 64'(ring), 64'h8);
        chk("ch3_stopped", 64'(running), 64'h0);
        rst = 1'b1;
        step(1);
        chk("rst_ring", 64'(ring), 64'h0);
        chk("rst_leds", all_leds(), 64'h0);
        rst = 1'b0;
        step(1);
        chk("post_rst_disp", all_leds(),
            64'({6'h03, 6'h0A, 6'h00, 6'h10, 6'h00, 6'h10, 6'h00, 6'h00}));
        ch_sel = 2'd1;
        step(1);
        chk("post_rst_ch1", 64'({led5, led4, led3, led2, led1, led0}),
            64'({6'h00, 6'h10, 6'h00, 6'h10, 6'h00, 6'h00}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_bank.md
# countdown_bank

Parametrised bank of N_CH independent countdown timers with hours/minutes/seconds editing, auto-repeat up/down buttons, per-channel ring outputs and an 8-digit display encoder. It is the multi-channel successor to the single-timer display/edit path. It sits between the button/mode controller and the seven-segment scanner, and it drives the same 6-bit {blink, dot, bcd} digit format.

## Interface
Parameters:
- N_CH, 4: number of timer channels (1..16).
- TICK_CYC, 50_000_000: clk cycles per 1 s countdown tick.
- REP_DELAY, 25_000_000: hold cycles before auto-repeat starts.
- REP_PERIOD, 5_000_000: cycles between auto-repeat steps.
- RING_SEC, 10: ring duration in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- ch_sel  in  $clog2(N_CH) (min 1)  channel shown and edited.
- field  in  2  edit field: 0 none, 1 seconds, 2 minutes, 3 hours.
- start  in  1  one-cycle pulse: start the selected channel.
- stop  in  1  one-cycle pulse: pause the selected channel and clear its ring.
- up_btn, down_btn  in  1 each  debounced, active-low (pressed = 0).
- led0..led7  out  6 each  {blink, dot, bcd[3:0]}.
- ring  out  N_CH  per-channel alarm.
- running  out  N_CH  per-channel run flag.

## Operation
- Channel state: BCD hours 00-99, minutes 00-59, seconds 00-59, a run flag, and a ring counter of $clog2(RING_SEC+1) bits.
- Prescaler: a single shared counter runs 0..TICK_CYC-1. A tick is issued in the cycle the count equals TICK_CYC-1.
- Countdown: on a tick, each running channel decrements with borrow (sec 00→59 borrows from min; min 00→59 borrows from hour).
  - A decrement that reaches 00:00:00 clears run, loads ring counter = RING_SEC, and asserts ring.
- Ring: the ring counter decrements on each tick, and ring = (counter != 0).
  - stop or start on that channel clears it immediately.
- start: ignored if the selected channel is at 00:00:00 or already running.
- Editing: enabled only when field != 0 and the selected channel is not running. A step changes only the chosen field, with wrap and no carry:
  - seconds and minutes: 59↔00.
  - hours: 99↔00.
- Buttons: each button runs through a btn_repeat instance that emits a one-cycle step:
  - on a 1→0 sampled transition;
  - again when held REP_DELAY cycles;
  - then every REP_PERIOD cycles while still held.
  - Both buttons low: no steps, and both hold counters clear.
  - A step arriving while editing is disabled is discarded.
- Display (selected channel):
  - led7 = ch_sel (low 4 bits).
  - led6 = 4'hA (dash).
  - led5/led4 = hours tens/ones.
  - led3/led2 = minutes.
  - led1/led0 = seconds.
  - Dot bits set on led4 and led2. All other dot bits are 0.
  - Blink bits set on the two digits of the edited field while editing is enabled; otherwise 0.

## Timing
- Reset values: every channel 00:00:00, run=0, ring counter=0, prescaler=0, btn_repeat counters 0, all led outputs 6'b0, ring=0, running=0.
- Button step: the field register updates on the clock edge that first samples the button low. The led outputs show the new value one edge later.
- Display latency: led outputs are registered and reflect ch_sel/field/channel state with 1-cycle latency. ring and running are registered directly from channel state (0 extra cycles).
- start pulse in cycle k: running=1 after edge k. A tick in cycle k is not applied to that channel; the first decrement happens on the next tick.
- stop and tick in the same cycle: stop wins and no decrement is applied.
- start and stop in the same cycle: stop wins.
- ch_sel change mid-hold: the hold counters keep running, and subsequent steps apply to the newly selected channel.
- rst asserted mid-countdown or mid-ring: all state returns to reset values at that edge.

## Structure
- Shared package clock_pkg:
  - field codes (FLD_NONE/SEC/MIN/HOUR);
  - the display-state localparams (TIME_DISP..TIMER_EDIT_HOUR);
  - the dash code 4'hA;
  - BCD increment/decrement-with-wrap functions parametrised by limit.
- Sub-module btn_repeat: clk, rst, btn_n, parameters REP_DELAY/REP_PERIOD, output step. Instantiated twice, once per button.
- The channel array is implemented as a generate loop over N_CH.

## Test plan
The bench uses TICK_CYC=10, REP_DELAY=20, REP_PERIOD=5, RING_SEC=3, N_CH=4.
- Reset, then observe: all led = 6'b0 until the first display update; then led7..0 digits = 0,A,0,0,0,0,0,0, running=0, ring=0.
- Load ch1 to 00:01:02 by editing with field=1 and field=2; pulse start. Expected: running[1]=1; after 62 ticks, running[1]=0 and ring[1]=1 for exactly 3 ticks; ch0/2/3 unchanged.
- Edit wrap: field=1 on 00:00:59, one up press → 00:00:00 with minutes still 00. field=3 on 00:00:00, one down press → 99:00:00.
- Auto-repeat: hold up_btn low for 40 cycles with field=1 from 00. Expected: steps at hold cycles 0, 20, 25, 30, 35 → seconds = 05. Both buttons low together → no change.
- Editing blocked: on a running channel, press up → value unchanged and blink bits all 0. Pulse stop → running=0, blink set on the led1/led0 pair.
- Simultaneous events: stop and tick in the same cycle → no decrement. start on 00:00:00 → ignored. rst during ring → ring=0 on the next edge.
